// File: rtl/genram_rr_arbiter_pkg.sv
// Shared definitions for the round-robin RAM arbiter: sizing helper,
// requester index type and the "no owner" encoding.
package genram_rr_arbiter_pkg;

  // Ceiling log2, never less than 1 so a 2-entry thing still gets a bit.
  function automatic int clogb2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

  // Largest requester count the arbiter is built for.
  localparam int MAX_NREQ = 16;

  // Requester index plus one spare bit, so OWNER_NONE never aliases a real index.
  localparam int REQ_IDX_W = clogb2(MAX_NREQ) + 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Owner register value meaning "no burst lock held".
  localparam req_idx_t OWNER_NONE = '1;

endpackage

// File: rtl/genram_rr_pick.sv
// Combinational round-robin search: first requester with i_req set,
// starting at i_ptr and wrapping past NREQ-1 back to 0.
module genram_rr_pick
  import genram_rr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clogb2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] NREQ_S = SUM_W'(NREQ);

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk the candidates in priority order from i_ptr; keep the first hit.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum  = {1'b0, i_ptr} + SUM_W'(i);
      w_cand = (w_sum >= NREQ_S) ? IDX_W'(w_sum - NREQ_S) : w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/genram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ clients,
// with a short burst lock and read-tag tracking so each read result is
// flagged back to the requester that issued it.
module genram_rr_arbiter
  import genram_rr_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          we_i,
  input  logic [NREQ*ADDR_W-1:0]   addr_i,
  input  logic [NREQ*DATA_W-1:0]   wdata_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [NREQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     ram_en_o,
  output logic                     ram_we_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [DATA_W-1:0]        ram_d_o,
  input  logic [DATA_W-1:0]        ram_q_i
);

  localparam int IDX_W = clogb2(NREQ);
  localparam int CNT_W = clogb2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // Arbitration state
  logic [IDX_W-1:0] r_ptr;
  req_idx_t         r_owner;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [NREQ-1:0]  r_rvalid;

  // Per-requester unpacked views of the packed buses
  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];

  logic             w_owner_valid;
  logic [IDX_W-1:0] w_owner_idx;
  logic             w_lock;
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_gnt_valid;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_is_owner;
  logic [IDX_W-1:0] w_ptr_next;
  logic             w_rd_issue;
  logic [NREQ-1:0]  w_rd_issue_onehot;
  logic [NREQ-1:0]  w_rd_tag_onehot;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ordinary round-robin candidate, used whenever the burst lock does not apply.
  genram_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // The owner keeps the RAM while it still requests and has burst budget left.
  assign w_owner_valid = (r_owner != OWNER_NONE);
  assign w_owner_idx   = r_owner[IDX_W-1:0];
  assign w_lock        = w_owner_valid && req_i[w_owner_idx] && (r_burst_cnt < BURST_MAX);

  // Combinational outputs are forced idle while reset is held.
  assign w_gnt_valid    = rst_n_i && (w_lock || w_pick_valid);
  assign w_gnt_idx      = w_lock ? w_owner_idx : w_pick_idx;
  assign w_gnt_is_owner = w_owner_valid && (w_gnt_idx == w_owner_idx);
  assign w_ptr_next     = (w_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : (w_gnt_idx + 1'b1);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack_o[gi] = w_gnt_valid && (w_gnt_idx == IDX_W'(gi));
    end
  endgenerate

  // RAM port is a straight mux of the granted requester's fields.
  assign ram_en_o   = w_gnt_valid;
  assign ram_we_o   = w_gnt_valid && we_i[w_gnt_idx];
  assign ram_addr_o = w_addr[w_gnt_idx];
  assign ram_d_o    = w_wdata[w_gnt_idx];

  // Read data is shared; rvalid_o tells which requester it belongs to.
  assign rdata_o = ram_q_i;

  // Reads launched this cycle, as a one-hot by requester.
  assign w_rd_issue        = w_gnt_valid && !we_i[w_gnt_idx];
  assign w_rd_issue_onehot = ack_o & {NREQ{w_rd_issue}};

  // Pointer, owner and burst counter; an idle cycle always drops the lock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr       <= '0;
      r_owner     <= OWNER_NONE;
      r_burst_cnt <= '0;
    end else if (w_gnt_valid) begin
      if (w_gnt_is_owner) begin
        // Saturate: once the budget is spent the owner only wins through plain RR.
        if (r_burst_cnt != BURST_MAX) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end else begin
        r_owner     <= REQ_IDX_W'(w_gnt_idx);
        r_burst_cnt <= CNT_W'(1);
      end
      r_ptr <= w_ptr_next;
    end else begin
      r_owner     <= OWNER_NONE;
      r_burst_cnt <= '0;
    end
  end

  // Read tag delay: the rvalid register itself supplies the final cycle of latency.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign w_rd_tag_onehot = w_rd_issue_onehot;
    end else begin : g_latn
      localparam int TAG_D = RD_LATENCY - 1;

      logic [TAG_D-1:0]            r_tag_vld;
      logic [TAG_D-1:0][IDX_W-1:0] r_tag_idx;

      // Shift {valid, index} of each launched read toward the rvalid register.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_tag_vld <= '0;
          r_tag_idx <= '0;
        end else begin
          r_tag_vld[0] <= w_rd_issue;
          r_tag_idx[0] <= w_gnt_idx;
          for (int i = 1; i < TAG_D; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
          end
        end
      end

      for (gi = 0; gi < NREQ; gi++) begin : g_dec
        assign w_rd_tag_onehot[gi] = r_tag_vld[TAG_D-1] && (r_tag_idx[TAG_D-1] == IDX_W'(gi));
      end
    end
  endgenerate

  // Registered one-hot rvalid, lined up with ram_q_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_rd_tag_onehot;
    end
  end

  assign rvalid_o = r_rvalid;

endmodule

// File: tb/tb_genram_rr_arbiter.sv
// Bench for genram_rr_arbiter: two instances (MAX_BURST 2 and 1, read
// latency 2) each with a behavioural RAM and a reference model.
module tb_genram_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LAT  = 2;

  logic clk;
  logic rst_n;

  logic [NREQ-1:0]    req_s  [2];
  logic [NREQ-1:0]    we_s   [2];
  logic [NREQ*AW-1:0] addr_s [2];
  logic [NREQ*DW-1:0] wd_s   [2];

  logic [NREQ-1:0] ack   [2];
  logic [NREQ-1:0] rv    [2];
  logic [DW-1:0]   rdata [2];
  logic            en    [2];
  logic            rwe   [2];
  logic [AW-1:0]   raddr [2];
  logic [DW-1:0]   rd    [2];

  // Environment RAMs (latency 2)
  logic [DW-1:0] env_mem [2][1024];
  logic [DW-1:0] p0 [2];
  logic [DW-1:0] p1 [2];
  bit            env_init = 1'b0;

  // Reference model
  int            m_owner [2];
  int            m_cnt   [2];
  int            m_ptr   [2];
  int            m_g     [2];
  int            mb      [2];
  logic [3:0]    m_rv    [2][4];
  logic [DW-1:0] m_rdd   [2][4];
  logic [DW-1:0] m_mem   [2][1024];
  int            cyc;

  // Stimulus state
  bit            p_act  [2][4];
  bit            p_we   [2][4];
  bit            p_keep [2][4];
  logic [AW-1:0] p_addr [2][4];
  logic [DW-1:0] p_dat  [2][4];
  bit            rnd_on;
  bit            rst_drive;

  int n_vec;
  int n_mis;

  genram_rr_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_BURST(2)
  ) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_s[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .wdata_i(wd_s[0]), .ack_o(ack[0]), .rvalid_o(rv[0]),
    .rdata_o(rdata[0]), .ram_en_o(en[0]), .ram_we_o(rwe[0]),
    .ram_addr_o(raddr[0]), .ram_d_o(rd[0]), .ram_q_i(p1[0])
  );

  genram_rr_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_BURST(1)
  ) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_s[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .wdata_i(wd_s[1]), .ack_o(ack[1]), .rvalid_o(rv[1]),
    .rdata_o(rdata[1]), .ram_en_o(en[1]), .ram_we_o(rwe[1]),
    .ram_addr_o(raddr[1]), .ram_d_o(rd[1]), .ram_q_i(p1[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hA500_0000 ^ (a * 32'h0001_0101);
  endfunction

  // Behavioural single-port RAM with two-cycle read latency
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 1024; a++)
          env_mem[i][a] <= pat(a);
      env_init <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en[i] && rwe[i]) env_mem[i][raddr[i]] <= rd[i];
        else if (en[i]) p0[i] <= env_mem[i][raddr[i]];
      end
    end
    for (int i = 0; i < 2; i++) p1[i] <= p0[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int n);
    m_owner[n] = -1;
    m_cnt[n]   = 0;
    m_ptr[n]   = 0;
    m_g[n]     = -1;
    for (int j = 0; j < 4; j++) m_rv[n][j] = '0;
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        req_s[n][k]            = p_act[n][k];
        we_s[n][k]             = p_we[n][k];
        addr_s[n][k*AW +: AW]  = p_addr[n][k];
        wd_s[n][k*DW +: DW]    = p_dat[n][k];
      end
    end
    rst_n = rst_drive;
  endtask

  task automatic refresh();
    if (rnd_on) begin
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < 4; k++) begin
          if (!p_act[n][k] && $urandom_range(0, 1) == 1) begin
            p_act[n][k]  = 1'b1;
            p_we[n][k]   = ($urandom_range(0, 2) == 0);
            p_addr[n][k] = AW'($urandom_range(0, 15));
            p_dat[n][k]  = $urandom;
          end
        end
      end
    end
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model
  task automatic model_check();
    for (int n = 0; n < 2; n++) begin
      int            s;
      int            g;
      logic [3:0]    erv;
      logic [DW-1:0] erd;
      logic          ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (!rst_n) begin
        chk($sformatf("ack_in_reset[%0d]", n), ack[n], 0);
        chk($sformatf("ram_en_in_reset[%0d]", n), en[n], 0);
        chk($sformatf("rvalid_in_reset[%0d]", n), rv[n], 0);
        model_reset(n);
      end else begin
        s   = cyc % 4;
        erv = m_rv[n][s];
        erd = m_rdd[n][s];
        m_rv[n][s] = '0;
        g = -1;
        if (m_owner[n] >= 0 && req_s[n][m_owner[n]] && m_cnt[n] < mb[n]) begin
          g = m_owner[n];
        end else begin
          for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr[n] + i) % 4;
            if (g < 0 && req_s[n][k]) g = k;
          end
        end
        m_g[n] = g;
        chk($sformatf("ack[%0d]", n), ack[n], (g >= 0) ? (64'd1 << g) : 64'd0);
        chk($sformatf("ram_en[%0d]", n), en[n], (g >= 0) ? 64'd1 : 64'd0);
        if (g >= 0) begin
          ew = we_s[n][g];
          ea = addr_s[n][g*AW +: AW];
          ed = wd_s[n][g*DW +: DW];
          chk($sformatf("ram_we[%0d]", n), rwe[n], ew);
          chk($sformatf("ram_addr[%0d]", n), raddr[n], ea);
          if (ew) begin
            chk($sformatf("ram_d[%0d]", n), rd[n], ed);
            m_mem[n][ea] = ed;
          end else begin
            m_rv[n][(cyc + LAT) % 4]  = 4'(1 << g);
            m_rdd[n][(cyc + LAT) % 4] = m_mem[n][ea];
          end
          if (g == m_owner[n]) begin
            m_cnt[n]++;
          end else begin
            m_owner[n] = g;
            m_cnt[n]   = 1;
          end
          m_ptr[n] = (g + 1) % 4;
        end else begin
          chk($sformatf("ram_we_idle[%0d]", n), rwe[n], 0);
          m_owner[n] = -1;
          m_cnt[n]   = 0;
        end
        chk($sformatf("rvalid[%0d]", n), rv[n], erv);
        if (erv != 0) chk($sformatf("rdata[%0d]", n), rdata[n], erd);
      end
    end
    cyc++;
  endtask

  task automatic consume();
    for (int n = 0; n < 2; n++) begin
      if (m_g[n] >= 0 && !p_keep[n][m_g[n]]) p_act[n][m_g[n]] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    refresh();
    drive();
    @(negedge clk);
    model_check();
    consume();
  endtask

  task automatic clear_pend();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) begin
        p_act[n][k]  = 1'b0;
        p_keep[n][k] = 1'b0;
      end
  endtask

  task automatic set_req(input int n, input int k, input bit w, input int a,
                         input logic [DW-1:0] d, input bit keep);
    p_act[n][k]  = 1'b1;
    p_we[n][k]   = w;
    p_addr[n][k] = AW'(a);
    p_dat[n][k]  = d;
    p_keep[n][k] = keep;
  endtask

  logic [3:0] seq2 [9];
  logic [3:0] seq3 [9];

  initial begin
    n_vec = 0;
    n_mis = 0;
    cyc = 0;
    rst_drive = 1'b0;
    rnd_on = 1'b0;
    mb[0] = 2;
    mb[1] = 1;
    for (int n = 0; n < 2; n++) begin
      model_reset(n);
      for (int a = 0; a < 1024; a++) m_mem[n][a] = pat(a);
      for (int k = 0; k < 4; k++) begin
        p_act[n][k] = 0; p_we[n][k] = 0; p_keep[n][k] = 0;
        p_addr[n][k] = '0; p_dat[n][k] = '0;
      end
    end
    drive();

    // Reset held with every requester asking; instance 1 gets requesters 1 and 3
    for (int k = 0; k < 4; k++) set_req(0, k, 1'b0, k + 1, 32'h0, 1'b1);
    set_req(1, 1, 1'b0, 21, 32'h0, 1'b1);
    set_req(1, 3, 1'b0, 23, 32'h0, 1'b1);
    repeat (3) begin
      cycle();
      chk("reset_ack", ack[0], 0);
      chk("reset_ram_en", en[0], 0);
      chk("reset_rvalid", rv[0], 0);
    end

    // Release: continuous reads (burst 2) and strict alternation (burst 1)
    rst_drive = 1'b1;
    seq2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    seq3 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010};
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk($sformatf("burst2_ack_%0d", i), ack[0], seq2[i]);
      chk($sformatf("burst1_ack_%0d", i), ack[1], seq3[i]);
      if (i == 2) chk("burst2_rdata_first", rdata[0], pat(1));
      if (i == 4) chk("burst2_rdata_req1", rdata[0], pat(2));
      if (i >= 2) chk($sformatf("burst2_rvalid_%0d", i), rv[0], seq2[i-2]);
      if (i == 5) begin
        p_act[1][3]  = 1'b0;
        p_keep[1][3] = 1'b0;
      end
    end

    // Write then read back through another requester
    clear_pend();
    cycle();
    set_req(0, 0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0);
    cycle();
    chk("wr_ack", ack[0], 4'b0001);
    chk("wr_ram_we", rwe[0], 1);
    set_req(0, 2, 1'b0, 5, 32'h0, 1'b0);
    cycle();
    chk("rd_ack", ack[0], 4'b0100);
    chk("rd_ram_we", rwe[0], 0);
    cycle();
    cycle();
    chk("rd_rvalid", rv[0], 4'b0100);
    chk("rd_rdata", rdata[0], 32'hDEAD_BEEF);

    // Single requester pulsing every other cycle
    repeat (4) begin
      set_req(0, 2, 1'b0, 7, 32'h0, 1'b0);
      cycle();
      chk("pulse_ack", ack[0], 4'b0100);
      cycle();
      chk("pulse_idle_ack", ack[0], 4'b0000);
    end

    // Reset one cycle after a read ack drops the tag and rewinds ptr
    set_req(0, 1, 1'b0, 9, 32'h0, 1'b0);
    cycle();
    chk("pre_reset_ack", ack[0], 4'b0010);
    rst_drive = 1'b0;
    cycle();
    cycle();
    chk("dropped_rvalid", rv[0], 4'b0000);
    rst_drive = 1'b1;
    set_req(0, 1, 1'b0, 3, 32'h0, 1'b0);
    set_req(0, 3, 1'b0, 4, 32'h0, 1'b0);
    cycle();
    chk("ptr_restart_ack", ack[0], 4'b0010);
    repeat (4) cycle();

    // Randomised traffic with occasional reset pulses
    clear_pend();
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_drive = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rnd_on = 1'b0;
    rst_drive = 1'b1;
    clear_pend();
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
